// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DATA_BITS           = 8;
    localparam int DEFAULT_CLK_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for the raw serial line plus a falling-edge detect on the synchronized value.
module uart_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall_s
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Flops reset to 1 so that reset release on an idle line never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s   = r_sync;
    assign fall_s = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_mv.sv
// Hardened 8N1 UART receiver: synchronized input, 3-sample majority vote, false-start and break handling.
// Define UART_RX_PARITY_EN to receive one even-parity bit between the data and stop bits.
module uart_rx_mv
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 parity_err,
    output rx_state_t            o_dbg_state
);

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF_BIT + 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    logic w_rx_s;
    logic w_fall_s;
    logic w_pre;
    logic w_mid;
    logic w_dec;
    logic w_end;
    logic w_vote;

    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_dv;
    logic                 r_fe;
    logic                 r_busy;
    logic                 r_v0;
    logic                 r_v1;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_pe;
    logic                 w_par_bad;
`endif

    uart_bit_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rx_s  (w_rx_s),
        .fall_s(w_fall_s)
    );

    assign w_pre  = (r_cnt == CNT_PRE);
    assign w_mid  = (r_cnt == CNT_MID);
    assign w_dec  = (r_cnt == CNT_DEC);
    assign w_end  = (r_cnt == CNT_LAST);
    // Third sample is the live synchronized line, so the vote resolves on the decision cycle itself.
    assign w_vote = maj3(r_v0, r_v1, w_rx_s);
`ifdef UART_RX_PARITY_EN
    assign w_par_bad = ^{r_shift, r_par};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
            r_busy  <= 1'b0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_pe    <= 1'b0;
`endif
        end else begin
            r_dv <= 1'b0;
            r_fe <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pe <= 1'b0;
`endif
            if (w_pre) r_v0 <= w_rx_s;
            if (w_mid) r_v1 <= w_rx_s;

            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_busy <= 1'b0;
                    if (w_fall_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
                    if (w_dec && w_vote) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_end) begin
                        r_state <= DATA;
                        r_idx   <= '0;
                    end
                end

                DATA: begin
                    r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
                    if (w_dec) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_end) begin
                        if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
                    if (w_dec) r_par <= w_vote;
                    if (w_end) r_state <= STOP;
                end
`endif

                // The rest of the stop bit is not waited out so a start bit may follow immediately.
                STOP: begin
                    r_cnt <= w_end ? '0 : r_cnt + CNT_W'(1);
                    if (w_dec) begin
                        r_cnt <= '0;
                        if (!w_vote) begin
                            r_fe    <= 1'b1;
                            r_state <= BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (w_par_bad) begin
                            r_pe    <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_data  <= r_shift;
                            r_dv    <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_dv;
    assign frame_err   = r_fe;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = r_pe;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_mv.sv
// Self-checking bench for uart_rx_mv: directed and random serial frames against a waveform-level reference model.
module tb_uart_rx_mv;
    import uart_pkg::*;

    localparam int CPB  = 16;
    localparam int HB   = CPB / 2;
    localparam int MAXC = 40000;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int LAT = 2 + 9 * CPB + HB + 2 + (NB - 9) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       parity_err;
    rx_state_t  dbg_state;

    uart_rx_mv #(.CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .parity_err (parity_err),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          multi = 0;
    int          win_s = 0;
    logic [7:0]  exp_data = 8'h00;
    logic        line_q[$];
    logic        hist[0:MAXC];
    logic        busy_hist[0:MAXC];
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Line driver and output monitor; hist[n] is the raw level sampled at posedge n.
    always @(negedge clk) begin
        if (line_q.size() > 0) rx = line_q.pop_front();
        else rx = 1'b1;
        hist[cyc + 1] = rx;
        busy_hist[cyc] = busy;
        if (!rst) begin
            if (data_valid) obs_q.push_back({cyc[15:0], 2'd0, data_out});
            if (frame_err)  obs_q.push_back({cyc[15:0], 2'd1, 8'h00});
            if (parity_err) obs_q.push_back({cyc[15:0], 2'd2, 8'h00});
            if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) multi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] ev(input int c, input logic [1:0] k, input logic [7:0] v);
        return {c[15:0], k, v};
    endfunction

    function automatic logic vote3(input int i);
        return (hist[i] & hist[i+1]) | (hist[i] & hist[i+2]) | (hist[i+1] & hist[i+2]);
    endfunction

    function automatic int find_edge(input int s);
        for (int i = s + 1; i < MAXC; i++)
            if (hist[i-1] === 1'b1 && hist[i] === 1'b0) return i;
        return 0;
    endfunction

    // Reference: find raw start edges, vote three raw samples around each bit centre, emit expected pulses.
    task automatic run_model(input int s, input int e);
        int i;
        int a;
        logic [7:0] b;
        logic par;
        logic stop_v;
        i = s + 1;
        while (i < e) begin
            if (hist[i-1] && !hist[i]) begin
                a = i;
                if (vote3(a + HB)) begin
                    i = a + HB + 3;
                end else begin
                    for (int k = 0; k < 8; k++) b[k] = vote3(a + (k + 1) * CPB + HB);
                    par = (NB == 10) ? vote3(a + 9 * CPB + HB) : 1'b0;
                    stop_v = vote3(a + NB * CPB + HB);
                    i = a + NB * CPB + HB + 3;
                    if (!stop_v) begin
                        exp_q.push_back(ev(a + NB * CPB + HB + 4, 2'd1, 8'h00));
                        while (i < e && !hist[i]) i++;
                    end else if (NB == 10 && (^{b, par})) begin
                        exp_q.push_back(ev(a + NB * CPB + HB + 4, 2'd2, 8'h00));
                    end else begin
                        exp_q.push_back(ev(a + NB * CPB + HB + 4, 2'd0, b));
                        exp_data = b;
                    end
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic push_level(input logic v, input int n);
        repeat (n) line_q.push_back(v);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip, input int glitch);
        logic bits[$];
        logic f[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(b[k]);
        if (NB == 10) bits.push_back((^b) ^ par_flip);
        bits.push_back(stop_v);
        foreach (bits[k]) repeat (CPB) f.push_back(bits[k]);
        if (glitch >= 0) f[glitch] = ~f[glitch];
        foreach (f[k]) line_q.push_back(f[k]);
    endtask

    task automatic wait_drain(input int tail);
        int guard;
        guard = 0;
        while (line_q.size() > 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", (guard < 20000), 1);
        repeat (tail) @(negedge clk);
    endtask

    task automatic open_window();
        win_s = cyc;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic close_window(input string tag);
        logic [25:0] o;
        logic [25:0] e;
        run_model(win_s, cyc);
        check({tag, ":count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
            check({tag, ":event"}, o, e);
        end
        obs_q.delete();
        check({tag, ":data_out"}, data_out, exp_data);
    endtask

    initial begin
        int a;
        int lows;
        int fe_n;
        int pe_n;
        int dv_n;
        int g;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst:data_out", data_out, 0);
        check("rst:data_valid", data_valid, 0);
        check("rst:frame_err", frame_err, 0);
        check("rst:parity_err", parity_err, 0);
        check("rst:busy", busy, 0);
        check("rst:state", dbg_state, IDLE);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean 0xA5 frame: latency and busy coverage
        open_window();
        push_level(1'b1, 4);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        wait_drain(2 * CPB);
        a = find_edge(win_s);
        lows = 0;
        for (int c = a + 2; c < a + LAT; c++) if (busy_hist[c] !== 1'b1) lows++;
        check("a5:busy_hold", lows, 0);
        check("a5:latency", (obs_q.size() > 0) ? obs_q[0][25:10] : 16'hFFFF, 16'((a + LAT) & 16'hFFFF));
        close_window("a5");
        check("a5:byte", data_out, 8'hA5);

        // False start of 5 cycles, then a good 0x3C frame
        open_window();
        push_level(1'b1, 4);
        push_level(1'b0, 5);
        push_level(1'b1, 2 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        wait_drain(2 * CPB);
        a = find_edge(win_s);
        check("fs:busy_set", busy_hist[a + 5], 1);
        check("fs:busy_idle", busy_hist[a + 12], 0);
        close_window("fs");
        check("fs:byte", data_out, 8'h3C);

        // 0x5A with a one-cycle glitch on the centre sample of data bit 2
        open_window();
        push_level(1'b1, 4);
        send_frame(8'h5A, 1'b1, 1'b0, 3 * CPB + HB + 1);
        wait_drain(2 * CPB);
        close_window("glitch");
        check("glitch:byte", data_out, 8'h5A);

        // Stop bit low followed by a 40-bit break
        open_window();
        push_level(1'b1, 4);
        send_frame(8'hC3, 1'b0, 1'b0, -1);
        push_level(1'b0, 40 * CPB);
        push_level(1'b1, 2 * CPB);
        wait_drain(2 * CPB);
        a = find_edge(win_s);
        fe_n = 0;
        foreach (obs_q[k]) if (obs_q[k][9:8] == 2'd1) fe_n++;
        check("brk:fe_count", fe_n, 1);
        check("brk:busy_mid", busy_hist[a + LAT + 20 * CPB], 1);
        check("brk:busy_end", busy_hist[cyc], 0);
        close_window("brk");
        check("brk:byte_kept", data_out, 8'h5A);

        // Back-to-back 0x00 then 0xFF with no idle gap
        open_window();
        push_level(1'b1, 4);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        wait_drain(2 * CPB);
        check("b2b:n", obs_q.size(), 2);
        check("b2b:spacing", (obs_q.size() == 2) ? int'(obs_q[1][25:10]) - int'(obs_q[0][25:10]) : -1,
              (NB + 1) * CPB);
        close_window("b2b");
        check("b2b:byte", data_out, 8'hFF);

        // Random bytes, random gaps, optional single-cycle glitch inside the data bits
        open_window();
        for (int n = 0; n < 8; n++) begin
            push_level(1'b1, $urandom_range(1, 2 * CPB));
            g = ($urandom_range(0, 1) == 1) ? CPB + $urandom_range(0, 8 * CPB - 1) : -1;
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, g);
        end
        wait_drain(2 * CPB);
        close_window("rnd");

        // Reset in the middle of the data bits of 0x81
        open_window();
        push_level(1'b1, 4);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        repeat (4 + 5 * CPB) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst:data_out", data_out, 0);
        check("mid_rst:busy", busy, 0);
        check("mid_rst:data_valid", data_valid, 0);
        check("mid_rst:state", dbg_state, IDLE);
        line_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        repeat (12 * CPB) @(negedge clk);
        check("mid_rst:no_pulse", obs_q.size(), 0);
        check("mid_rst:data_after", data_out, 0);
        obs_q.delete();

`ifdef UART_RX_PARITY_EN
        // 0x81 with its parity bit inverted
        open_window();
        push_level(1'b1, 4);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        wait_drain(2 * CPB);
        pe_n = 0;
        dv_n = 0;
        foreach (obs_q[k]) begin
            if (obs_q[k][9:8] == 2'd2) pe_n++;
            if (obs_q[k][9:8] == 2'd0) dv_n++;
        end
        check("par:pe_count", pe_n, 1);
        check("par:dv_count", dv_n, 0);
        close_window("par");
`else
        pe_n = 0;
        dv_n = 0;
        check("par:tied_low", parity_err, pe_n);
`endif

        check("exclusive", multi, dv_n);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_mv.md
Name: uart_rx_mv

Overview:
- Hardened UART receiver: the receive end of the 8N1 serial link that the team's UART transmitter drives.
- Adds a 2-flop input synchronizer, 3-sample majority vote at each bit centre, false-start rejection, framing-error reporting and break handling.
- Intended as a drop-in receive path for the full-duplex UART top level, running on the same system clock.

Parameters:
- CLK_PER_BIT, 434, system clock cycles per serial bit; minimum 4.
- HALF_BIT, CLK_PER_BIT/2, cycle offset from bit start to bit centre; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  raw serial line, idle high, asynchronous to clk
- data_out  output  8  last correctly framed byte; held until the next good frame
- data_valid  output  1  one-cycle pulse; data_out is new this cycle
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high from accepted start edge until return to IDLE
- parity_err  output  1  one-cycle pulse; parity mismatch (see Optional Feature)

Behaviour:
- Reset:
  - One clock domain; reset is asynchronous and active-high.
  - All outputs reset to 0; synchronizer flops reset to 1 (idle line); state reset to IDLE; counters reset to 0.
  - Reset asserted mid-frame aborts the frame. No pulse is emitted and data_out is cleared.
- Synchronizer: rx passes through 2 flops to give rx_s. All timing below is relative to rx_s (raw rx plus 2 cycles).
- Timing reference: a cycle counter cnt (0..CLK_PER_BIT-1) restarts at each bit boundary. Bit centre is cnt == HALF_BIT.
- Majority vote: samples at cnt == HALF_BIT-1, HALF_BIT and HALF_BIT+1. The bit decision is taken at cnt == HALF_BIT+1 as majority(3).
- States:
  - IDLE: busy=0. On an rx_s falling edge (previous 1, current 0), cnt<=0 and go to START.
  - START: at the decision point, if majority is 1, this is a false start → IDLE with no pulses. Otherwise continue; at cnt == CLK_PER_BIT-1 go to DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into a shift register at each decision point. At cnt == CLK_PER_BIT-1 on bit 7, go to STOP (or PARITY if enabled).
  - STOP: at the decision point:
    - majority 1: data_out <= shift register and data_valid pulses on the next cycle → IDLE. The stop-bit remainder is not waited out, so back-to-back frames are accepted.
    - majority 0: frame_err pulses on the next cycle; data_out is unchanged → BREAK.
  - BREAK: busy stays 1; wait until rx_s == 1 → IDLE. A held-low line (break) yields exactly one frame_err.
- Latency: data_valid rises 9*CLK_PER_BIT + HALF_BIT + 2 cycles after the rx_s falling edge (+2 from raw rx).
- A falling edge during START/DATA/STOP is ignored; only the state machine timing applies.
- data_valid, frame_err and parity_err are mutually exclusive in any cycle.
- Counters: cnt is $clog2(CLK_PER_BIT) bits wide; the bit index is 3 bits. No wrap beyond the defined terminal counts.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA; one even-parity bit is sampled by majority vote.
  - At the STOP decision, if parity mismatched, parity_err pulses instead of data_valid and data_out is unchanged.
  - A framing error takes precedence (frame_err only).
  - Frame length is 11 bits; latency is +CLK_PER_BIT.
- Undefined: no PARITY state; parity_err is tied to 0.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK}
  - localparam DATA_BITS=8
  - shared default CLK_PER_BIT=434
- Sub-module uart_bit_sync: 2-flop synchronizer plus falling-edge detect, outputs rx_s and fall_s; reset value 1.

Test Plan (CLK_PER_BIT=16, HALF_BIT=8):
- Frame 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) → data_out=0xA5, one data_valid pulse 154 cycles after the raw-rx edge+2, busy high throughout.
- rx low for 5 cycles then high → no pulses; busy returns to 0 by cycle 10 after the edge; a following 0x3C frame decodes correctly.
- Frame 0x5A with a single-cycle glitch at the centre of bit 2 → data_out=0x5A (majority vote).
- Stop bit driven 0, then line held low for 40 bit times → exactly one frame_err pulse, data_out retains the prior value, busy until rx returns high.
- Back-to-back 0x00 then 0xFF with no idle gap → two data_valid pulses 160 cycles apart, values 0x00 then 0xFF.
- Reset asserted mid-DATA of 0x81 → outputs 0 immediately, no pulse; with UART_RX_PARITY_EN, 0x81 sent with parity 1 → parity_err pulse, no data_valid.
